// File: rtl/four_req_rr_arbiter.sv
// Four-requester round-robin arbiter with a registered one-hot grant and bounded tenure.
// Define GRANT_COUNT_EN to add gnt_count, an 8-bit wrapping count of tenures started.
module four_req_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic       any_req,
    output logic [3:0] gnt,
    output logic       gnt_valid,
    output logic [1:0] gnt_id
`ifdef GRANT_COUNT_EN
    ,
    output logic [7:0] gnt_count
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [1:0] last_q, last_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] gnt_q, gnt_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic [1:0] gnt_id_q, gnt_id_d;
    logic [1:0] winner;
    logic       release_own;
    logic       new_tenure;

    // First set request searching last+1, last+2, last+3, last (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (r[idx] && !found) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign any_req = |req;

    // While in GRANT the pointer equals the current owner.
    assign winner      = rr_pick(req, last_q);
    assign release_own = !req[last_q] || (hold_q == HOLD_LAST);

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        last_d      = last_q;
        hold_d      = hold_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        new_tenure  = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) new_tenure = 1'b1;
            end
            GRANT: begin
                if (!release_own) begin
                    hold_d = hold_q + 8'd1;
                end else if (any_req) begin
                    new_tenure = 1'b1;
                end else begin
                    state_d     = IDLE;
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (new_tenure) begin
            state_d     = GRANT;
            last_d      = winner;
            hold_d      = 8'd0;
            gnt_d       = 4'b0001 << winner;
            gnt_valid_d = 1'b1;
            gnt_id_d    = winner;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 2'd3;
            hold_q      <= 8'd0;
            gnt_q       <= 4'b0000;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;

`ifdef GRANT_COUNT_EN
    logic [7:0] gnt_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_count_q <= 8'd0;
        end else if (new_tenure) begin
            gnt_count_q <= gnt_count_q + 8'd1;
        end
    end

    assign gnt_count = gnt_count_q;
`endif

endmodule

// File: tb/tb_four_req_rr_arbiter.sv
// Directed bench for four_req_rr_arbiter: two instances (MAX_HOLD=4 and 3) on shared stimulus,
// expected grants queued when req is driven and compared one edge later.
module tb_four_req_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'b0000;

    logic       any4, any3, gv4, gv3;
    logic [3:0] g4, g3;
    logic [1:0] id4, id3;
`ifdef GRANT_COUNT_EN
    logic [7:0] cnt4, cnt3;
`endif

    four_req_rr_arbiter #(.MAX_HOLD(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .any_req   (any4),
        .gnt       (g4),
        .gnt_valid (gv4),
        .gnt_id    (id4)
`ifdef GRANT_COUNT_EN
        ,
        .gnt_count (cnt4)
`endif
    );

    four_req_rr_arbiter #(.MAX_HOLD(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .any_req   (any3),
        .gnt       (g3),
        .gnt_valid (gv3),
        .gnt_id    (id3)
`ifdef GRANT_COUNT_EN
        ,
        .gnt_count (cnt3)
`endif
    );

    typedef struct {
        string      tag;
        logic [3:0] gnt;
        logic [1:0] id;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   fails  = 0;
    bit   use3   = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, check any_req combinationally, then check the registered grant.
    task automatic cyc(input logic rst, input logic [3:0] r, input logic [3:0] eg,
                       input logic [1:0] eid, input string tag);
        exp_t e;
        rst_n = rst;
        req   = r;
        e.tag = tag;
        e.gnt = eg;
        e.id  = eid;
        sb.push_back(e);
        #1;
        chk({tag, ".any_req"}, {7'd0, (use3 ? any3 : any4)}, {7'd0, |r});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".gnt"},       {4'd0, (use3 ? g3 : g4)},   {4'd0, e.gnt});
        chk({e.tag, ".gnt_valid"}, {7'd0, (use3 ? gv3 : gv4)}, {7'd0, |e.gnt});
        chk({e.tag, ".gnt_id"},    {6'd0, (use3 ? id3 : id4)}, {6'd0, e.id});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;

        // Reset then idle; any_req must follow req even in reset.
        cyc(1'b0, 4'b0000, 4'b0000, 2'd0, "rst0");
        cyc(1'b0, 4'b0000, 4'b0000, 2'd0, "rst1");
        cyc(1'b0, 4'b0010, 4'b0000, 2'd0, "rst_any");

        // Single request, hold, drop; gnt_id keeps its value while idle.
        cyc(1'b1, 4'b0100, 4'b0100, 2'd2, "single_on");
        cyc(1'b1, 4'b0100, 4'b0100, 2'd2, "single_hold");
        cyc(1'b1, 4'b0000, 4'b0000, 2'd2, "single_drop");
        cyc(1'b1, 4'b0000, 4'b0000, 2'd2, "idle_id_hold");

        // All four requesting with MAX_HOLD=4: four-cycle tenures, no gaps.
        cyc(1'b0, 4'b0000, 4'b0000, 2'd0, "rst_t3");
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 4'b1111, 4'b0001 << ((i / 4) % 4), 2'((i / 4) % 4), "rr_all");
        end

        // Pointer rotation, same-edge handoff, no mid-tenure revocation.
        cyc(1'b1, 4'b0000, 4'b0000, 2'd0, "t4_drop");
        cyc(1'b1, 4'b0010, 4'b0010, 2'd1, "t4_b");
        cyc(1'b1, 4'b0000, 4'b0000, 2'd1, "t4_b_rel");
        cyc(1'b1, 4'b0011, 4'b0001, 2'd0, "t4_rot");
        cyc(1'b1, 4'b0010, 4'b0010, 2'd1, "t4_handoff");
        cyc(1'b1, 4'b0011, 4'b0010, 2'd1, "t4_norevoke");
        cyc(1'b1, 4'b0001, 4'b0001, 2'd0, "t4_to_a");
        cyc(1'b1, 4'b0000, 4'b0000, 2'd0, "t4_idle");

        // Sole requester on the MAX_HOLD=3 instance: continuous grant across expiries.
        cyc(1'b0, 4'b0000, 4'b0000, 2'd0, "rst_t5");
        use3 = 1'b1;
`ifdef GRANT_COUNT_EN
        chk("t5_count_reset", cnt3, 8'd0);
`endif
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 4'b1000, 4'b1000, 2'd3, "t5_sole");
        end
`ifdef GRANT_COUNT_EN
        chk("t5_count", cnt3, 8'd3);
`endif
        use3 = 1'b0;

        // Reset mid-tenure returns the pointer to 3.
        cyc(1'b1, 4'b0100, 4'b0100, 2'd2, "t6_to_c");
        cyc(1'b0, 4'b0100, 4'b0000, 2'd0, "t6_rst");
        cyc(1'b1, 4'b0101, 4'b0001, 2'd0, "t6_ptr");
        cyc(1'b1, 4'b0100, 4'b0100, 2'd2, "t6b_to_c");
        cyc(1'b0, 4'b1100, 4'b0000, 2'd0, "t6b_rst");
        cyc(1'b1, 4'b1100, 4'b0100, 2'd2, "t6b_ptr");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
